wsgen_ctl: RTL and testbench

Word-cycle sequencer that drives the A&R arithmetic register chip on `cph2`. Generates the 56-bit-time word timing, serialises one 10-bit instruction per word onto `is` with `sync` framing, and asserts `ws` over the digit field of each arithmetic instruction during the following word. Keeps the 4-bit pointer register used by pointer-relative fields, and latches the A&R `carry` for branch decisions upstream.

---
 rtl/wsgen_ctl.sv | 139 +++++++++++++
 tb/tb_wsgen_ctl.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/wsgen_ctl.sv
// Word-cycle sequencer for the A&R chip: 56 bit-time word timing, serial instruction
// framing on is/sync, ws digit-field select, pointer register (WSGEN_POINTER_EN) and carry latch.
module wsgen_ctl (
  input  logic       cph2,
  input  logic       rst,
  input  logic [9:0] instr,
  input  logic       instr_valid,
  output logic       instr_ready,
  input  logic       carry,
  output logic       sync,
  output logic       is,
  output logic       ws,
  output logic       word_start,
  output logic [3:0] ptr,
  output logic       cond
);

  typedef enum logic [1:0] {
    TYPE_0     = 2'b00,
    TYPE_PTR   = 2'b01,
    TYPE_ARITH = 2'b10,
    TYPE_3     = 2'b11
  } itype_e;

  typedef enum logic [2:0] {
    FLD_P  = 3'b000,
    FLD_M  = 3'b001,
    FLD_X  = 3'b010,
    FLD_W  = 3'b011,
    FLD_WP = 3'b100,
    FLD_MS = 3'b101,
    FLD_XS = 3'b110,
    FLD_S  = 3'b111
  } field_e;

  typedef enum logic [1:0] {
    POP_SET = 2'b00,
    POP_INC = 2'b01,
    POP_DEC = 2'b10,
    POP_NOP = 2'b11
  } ptr_op_e;

  localparam logic [5:0] LAST_CNT  = 6'd55;
  localparam logic [5:0] FETCH_CNT = 6'd44;
  localparam logic [5:0] WIN_FIRST = 6'd45;
  localparam logic [5:0] WIN_LAST  = 6'd54;
  localparam logic [3:0] MAX_DIGIT = 4'd13;
  localparam logic [9:0] NOP       = 10'h000;

  logic [5:0] cnt, cnt_nxt;
  logic [9:0] f_reg, f_nxt;
  // Only type and field of the executing instruction are needed during its word.
  logic [4:0] x_reg, x_nxt;
  logic [3:0] p_reg, p_nxt;
  logic       in_win;
  logic [3:0] bit_idx;
  logic [3:0] digit;
  logic [3:0] lo, hi;
  logic       ws_nxt;

  always_comb begin
    cnt_nxt = (cnt == LAST_CNT) ? '0 : cnt + 6'd1;

    f_nxt = f_reg;
    if (cnt == FETCH_CNT)
      f_nxt = instr_valid ? instr : NOP;

    x_nxt = x_reg;
    if (cnt == LAST_CNT)
      x_nxt = f_reg[4:0];
  end

  always_comb begin
`ifdef WSGEN_POINTER_EN
    p_nxt = p_reg;
    if (cnt == LAST_CNT && itype_e'(f_reg[1:0]) == TYPE_PTR) begin
      unique case (ptr_op_e'(f_reg[3:2]))
        POP_SET: p_nxt = (f_reg[9:6] > MAX_DIGIT) ? MAX_DIGIT : f_reg[9:6];
        POP_INC: p_nxt = (p_reg == MAX_DIGIT) ? '0 : p_reg + 4'd1;
        POP_DEC: p_nxt = (p_reg == '0) ? MAX_DIGIT : p_reg - 4'd1;
        POP_NOP: p_nxt = p_reg;
      endcase
    end
`else
    p_nxt = '0;
`endif
  end

  // Outputs are registered from next-count values so that at count k they reflect count k;
  // ws therefore decodes the instruction and pointer that take effect at this same edge.
  always_comb begin
    in_win  = (cnt_nxt >= WIN_FIRST) && (cnt_nxt <= WIN_LAST);
    bit_idx = 4'(cnt_nxt - WIN_FIRST);
    digit   = cnt_nxt[5:2];
    lo      = '0;
    hi      = '0;
    unique case (field_e'(x_nxt[4:2]))
      FLD_P:  begin lo = p_nxt; hi = p_nxt;     end
      FLD_M:  begin lo = 4'd3;  hi = 4'd12;     end
      FLD_X:  begin lo = 4'd0;  hi = 4'd2;      end
      FLD_W:  begin lo = 4'd0;  hi = MAX_DIGIT; end
      FLD_WP: begin lo = 4'd0;  hi = p_nxt;     end
      FLD_MS: begin lo = 4'd3;  hi = MAX_DIGIT; end
      FLD_XS: begin lo = 4'd2;  hi = 4'd2;      end
      FLD_S:  begin lo = MAX_DIGIT; hi = MAX_DIGIT; end
    endcase
    ws_nxt = (itype_e'(x_nxt[1:0]) == TYPE_ARITH) && (digit >= lo) && (digit <= hi);
  end

  always_ff @(posedge cph2) begin
    if (rst) begin
      cnt         <= '0;
      f_reg       <= NOP;
      x_reg       <= '0;
      p_reg       <= '0;
      cond        <= 1'b0;
      sync        <= 1'b0;
      is          <= 1'b0;
      ws          <= 1'b0;
      instr_ready <= 1'b0;
      word_start  <= 1'b1;
    end else begin
      cnt         <= cnt_nxt;
      f_reg       <= f_nxt;
      x_reg       <= x_nxt;
      p_reg       <= p_nxt;
      if (cnt == LAST_CNT)
        cond <= carry;
      sync        <= in_win;
      is          <= in_win & f_nxt[bit_idx];
      ws          <= ws_nxt;
      instr_ready <= (cnt_nxt == FETCH_CNT);
      word_start  <= (cnt_nxt == '0);
    end
  end

  assign ptr = p_reg;

endmodule

// File: tb/tb_wsgen_ctl.sv
// Randomized self-checking bench for wsgen_ctl against a word-level reference model.
module tb_wsgen_ctl;

  logic       cph2 = 1'b0;
  logic       rst = 1'b1;
  logic [9:0] instr = '0;
  logic       instr_valid = 1'b0;
  logic       carry = 1'b0;
  logic       instr_ready, sync, is, ws, word_start, cond;
  logic [3:0] ptr;

  wsgen_ctl dut (
    .cph2(cph2), .rst(rst), .instr(instr), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .carry(carry), .sync(sync), .is(is), .ws(ws),
    .word_start(word_start), .ptr(ptr), .cond(cond)
  );

  always #5 cph2 = ~cph2;

  int errs = 0;
  int checks = 0;
  int cyc = 0;

  int         m_cnt = 0;
  int         m_p = 0;
  logic [9:0] m_f = '0;
  logic [9:0] m_x = '0;
  logic       m_cond = 1'b0;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s cyc=%0d cnt=%0d got=%0h exp=%0h", tag, cyc, m_cnt, got, exp);
    end
  endtask

  function automatic logic [13:0] digit_mask(input logic [2:0] fld, input int p);
    int lo, hi;
    logic [13:0] m;
    case (fld)
      3'd0: begin lo = p;  hi = p;  end
      3'd1: begin lo = 3;  hi = 12; end
      3'd2: begin lo = 0;  hi = 2;  end
      3'd3: begin lo = 0;  hi = 13; end
      3'd4: begin lo = 0;  hi = p;  end
      3'd5: begin lo = 3;  hi = 13; end
      3'd6: begin lo = 2;  hi = 2;  end
      default: begin lo = 13; hi = 13; end
    endcase
    m = '0;
    for (int d = lo; d <= hi; d++) m[d] = 1'b1;
    return m;
  endfunction

  task automatic model_edge(input logic r, input logic v, input logic [9:0] ins, input logic c);
    if (r) begin
      m_cnt = 0; m_f = '0; m_x = '0; m_p = 0; m_cond = 1'b0;
    end else begin
      if (m_cnt == 44) m_f = v ? ins : 10'h000;
      if (m_cnt == 55) begin
        m_x = m_f;
        m_cond = c;
`ifdef WSGEN_POINTER_EN
        if (m_f[1:0] == 2'b01) begin
          case (m_f[3:2])
            2'b00: m_p = (int'(m_f[9:6]) > 13) ? 13 : int'(m_f[9:6]);
            2'b01: m_p = (m_p + 1) % 14;
            2'b10: m_p = (m_p + 13) % 14;
            default: ;
          endcase
        end
`endif
      end
      m_cnt = (m_cnt + 1) % 56;
    end
  endtask

  task automatic compare();
    logic [13:0] msk;
    logic e_sync, e_is, e_ws;
    msk    = digit_mask(m_x[4:2], m_p);
    e_ws   = (m_x[1:0] == 2'b10) && msk[m_cnt / 4];
    e_sync = (m_cnt >= 45) && (m_cnt <= 54);
    e_is   = e_sync ? m_f[m_cnt - 45] : 1'b0;
    check("sync", 16'(sync), 16'(e_sync));
    check("is", 16'(is), 16'(e_is));
    check("ws", 16'(ws), 16'(e_ws));
    check("instr_ready", 16'(instr_ready), 16'(m_cnt == 44));
    check("word_start", 16'(word_start), 16'(m_cnt == 0));
    check("ptr", 16'(ptr), 16'(m_p));
    check("cond", 16'(cond), 16'(m_cond));
  endtask

  task automatic step(input logic r, input logic v, input logic [9:0] ins, input logic c);
    rst = r; instr_valid = v; instr = ins; carry = c;
    @(posedge cph2);
    model_edge(r, v, ins, c);
    cyc++;
    #1;
    compare();
  endtask

  // One word from count 0; instr is only meaningful at count 44, noise elsewhere.
  task automatic run_word(input logic v, input logic [9:0] ins, input logic c55, input int rst_at);
    for (int k = 0; k < 56; k++) begin
      logic rv, rc;
      logic [9:0] ri;
      if (m_cnt == 44) begin
        rv = v; ri = ins;
      end else begin
        rv = 1'($urandom); ri = 10'($urandom);
      end
      rc = (m_cnt == 55) ? c55 : 1'($urandom);
      if (m_cnt == rst_at) begin
        step(1'b1, rv, ri, rc);
        break;
      end
      step(1'b0, rv, ri, rc);
    end
  endtask

  initial begin
    step(1'b1, 1'b0, '0, 1'b0);
    step(1'b1, 1'b1, 10'h3ff, 1'b1);

    run_word(1'b0, '0, 1'b0, -1);
    run_word(1'b0, '0, 1'b0, -1);

    run_word(1'b1, 10'b00101_011_10, 1'b0, -1);
    run_word(1'b0, '0, 1'b0, -1);

    run_word(1'b1, 10'b0101_0_000_01, 1'b0, -1);
    run_word(1'b1, 10'b00000_100_10, 1'b0, -1);
    run_word(1'b0, '0, 1'b0, -1);

    run_word(1'b1, 10'b1101_0_000_01, 1'b0, -1);
    run_word(1'b1, 10'b00000_001_01, 1'b0, -1);
    run_word(1'b1, 10'b00000_000_10, 1'b0, -1);
    run_word(1'b1, 10'b00000_010_01, 1'b0, -1);
    run_word(1'b1, 10'b00000_100_10, 1'b0, -1);
    run_word(1'b1, 10'b1111_0_000_01, 1'b0, -1);
    run_word(1'b1, 10'b00000_000_10, 1'b0, -1);
    run_word(1'b0, '0, 1'b0, -1);

    run_word(1'b0, '0, 1'b1, -1);
    run_word(1'b0, '0, 1'b0, -1);

    run_word(1'b1, 10'b00101_011_10, 1'b0, -1);
    run_word(1'b0, '0, 1'b1, 30);
    run_word(1'b0, '0, 1'b0, -1);
    run_word(1'b0, '0, 1'b0, -1);

    for (int w = 0; w < 40; w++) begin
      logic [9:0] ri;
      ri = 10'($urandom);
      run_word($urandom_range(0, 3) != 0, ri, 1'($urandom), -1);
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
